mp_mul_sched: RTL
=================

Name: mp_mul_sched

Overview:
- Multi-precision multiply sequencer for the field-arithmetic datapath.
- Computes the full 2N-bit product of two N-bit operands by time-multiplexing one normal_multiplication_compute instance (W = N/6-bit operands, 2W-bit product) over the 6x6 limb pairs, using schoolbook order.
- Sits between the Fp/Fp2 arithmetic control and the shared W x W multiplier.
- The multiplier instance is internal to this block.

Parameters:
- N, 222, total operand width in bits. N must be divisible by 6. Derived localparam W = N/6 (37 at default); limb count is fixed at 6.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request pulse; a and b are sampled on the accepting edge
- a  input  N  multiplicand, limb k = a[W*k +: W]
- b  input  N  multiplier, limb k = b[W*k +: W]
- busy  output  1  high while partial products are being accumulated
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2N  full product a*b, held until the next accepted start

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, product=0, i=j=0, operand registers cleared. Reset has priority over every other event, including mid-MUL. An interrupted operation is abandoned and no done is produced.
- States: IDLE, MUL, DONE.
- IDLE:
  - If start=1 at the edge: latch a and b into the operand registers, clear the accumulator to 0, set i=0 and j=0, go to MUL, busy=1.
  - Otherwise stay in IDLE.
- MUL: each cycle:
  - The internal multiplier is fed a_reg limb i and b_reg limb j.
  - At the edge: acc <= acc + (pp << (W*(i+j))), where pp is the 2W-bit partial product.
  - The add is full 2N width with no truncation. The sum of partial products is at most (2^N-1)^2 < 2^(2N), so it never overflows.
  - Index order: j increments 0..5. When j=5, j wraps to 0 and i increments.
  - The accumulation with i=5, j=5 is the last one. At that edge go to DONE, busy<=0, done<=1.
  - MUL lasts exactly 36 cycles.
- DONE: lasts one cycle with done=1 and product valid.
  - If start=1 at this edge, it is accepted exactly as in IDLE (back-to-back): done<=0, go to MUL.
  - Otherwise go to IDLE with done<=0.
- Latency: start accepted at edge E. Accumulations occur at edges E+1..E+36. done=1 during the cycle after E+36, and is sampled high at edge E+37.
- product is the accumulator register itself.
  - It is stable and equal to a*b from the DONE cycle until the next accepted start.
  - At the next accepted start it is cleared to 0.
  - During MUL it shows partial sums and is don't-care to consumers.
- start while in MUL is ignored. It does not relatch operands and does not restart.
- Changes on a/b after acceptance have no effect.
- The multiplier path is combinational. No pipeline register is required at N=222. The critical path is the multiplier plus the 2N-bit add.

Test Plan:
- Zero/identity: a=0, b=arbitrary -> product=0. Then a=1, b=2^222-1 -> product=2^222-1. In both cases done is sampled high exactly at edge 37 after the accepting edge, and busy is high for 36 cycles.
- Max operands: a=b=2^222-1 -> product=2^444-2^223+1. This checks the carries across all limb boundaries and that the top bit is not truncated.
- Single high limbs: a=2^221, b=2^221 -> product=2^442. Then a=2^37 (limb 1), b=2^185 (limb 5) -> product=2^222. This checks the shift amount W*(i+j).
- Start while busy: start at cycle 0 with a=3, b=5. Pulse start again at cycle 10 with a=7, b=11 -> single done, product=15, done timing unchanged.
- Back-to-back: hold start=1 through DONE with new a=2^100, b=2^50 -> first product valid for one cycle, second done 37 cycles later with product=2^150.
- Reset mid-op: assert rst at cycle 20 of MUL -> next cycle busy=0, done=0, product=0, state IDLE. No done pulse follows. A subsequent start with a=6, b=7 gives product=42.
- Random: 500 random a/b pairs compared against a reference model of a*b.

Source files
------------

// File: rtl/mp_mul_sched.sv
`default_nettype none
// ============================================================================
// Module  : mp_mul_sched (+ normal_multiplication_compute)
// Brief   : Full 2N-bit multiply built by sequencing one W x W multiplier
//           over the 6x6 limb pairs in schoolbook order.
// Revision: 1.0
// ============================================================================

module normal_multiplication_compute #(
    parameter int W = 37
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);
    assign o_p = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
endmodule

module mp_mul_sched #(
    parameter int N = 222
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int         LIMBS   = 6;
    localparam int         W       = N / LIMBS;
    localparam int         PW      = 2 * N;
    localparam int         SHW     = $clog2(PW);
    localparam logic [2:0] C_LAST  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_a, w_a_nxt;
    logic [N-1:0]   r_b, w_b_nxt;
    logic [PW-1:0]  r_acc, w_acc_nxt;
    logic [2:0]     r_i, w_i_nxt;
    logic [2:0]     r_j, w_j_nxt;

    logic [W-1:0]   w_a_limb [LIMBS];
    logic [W-1:0]   w_b_limb [LIMBS];
    logic [W-1:0]   w_mul_a;
    logic [W-1:0]   w_mul_b;
    logic [2*W-1:0] w_pp;
    logic [SHW-1:0] w_shamt;
    logic [PW-1:0]  w_pp_shifted;

    for (genvar k = 0; k < LIMBS; k++) begin : g_limbs
        assign w_a_limb[k] = r_a[W*k +: W];
        assign w_b_limb[k] = r_b[W*k +: W];
    end

    assign w_mul_a = w_a_limb[r_i];
    assign w_mul_b = w_b_limb[r_j];

    normal_multiplication_compute #(
        .W (W)
    ) u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_pp)
    );

    // Limb pair (i,j) lands at bit W*(i+j); max shift 10*W stays inside 2N.
    assign w_shamt      = SHW'(W) * (SHW'(r_i) + SHW'(r_j));
    assign w_pp_shifted = {{(PW-2*W){1'b0}}, w_pp} << w_shamt;

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_MUL;
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_acc_nxt   = '0;
                    w_i_nxt     = 3'd0;
                    w_j_nxt     = 3'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                w_acc_nxt = r_acc + w_pp_shifted;
                if (r_j == C_LAST) begin
                    w_j_nxt = 3'd0;
                    if (r_i == C_LAST) begin
                        w_i_nxt     = 3'd0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_nxt = r_i + 3'd1;
                    end
                end else begin
                    w_j_nxt = r_j + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_i     <= 3'd0;
            r_j     <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
        end
    end

    assign busy    = (r_state == S_MUL);
    assign done    = (r_state == S_DONE);
    assign product = r_acc;

endmodule
`default_nettype wire
